ofdmbbp_rx_sched: RTL and testbench
===================================

Name: ofdmbbp_rx_sched

Overview:
Receive-packet sequencer between the software command queue and the RX demodulator core.
- Pops one command word and loads it into the RX core.
- Arms on the sync packet-detect flag, then pulses the core's start input.
- Counts demodulated output words until the commanded length is reached, waits the commanded pause, and repeats the command the commanded number of times.
- Supervises detect timeouts, data-queue overflow and software abort, and exports status counters for register readback.
- Sits in the sample-clock domain next to the sync and RX core instances.

Parameters:
CNT_W, 16, width of status counters and timeout counter
LEN_W, 8, width of cmd length field; length 0 means 2**LEN_W words

Ports:
clk  in  1  sample clock
rst  in  1  synchronous active-high reset
enable  in  1  scheduler enable; low aborts the operation in progress
timeout_limit  in  CNT_W  max cycles in WAIT_DET; 0 disables timeout
cmd_valid  in  1  command queue not empty
cmd_ready  out  1  pop strobe to command queue
cmd_length  in  LEN_W  output words per packet
cmd_mode  in  2  demod mode
cmd_seed  in  7  scrambler seed
cmd_repeat  in  7  extra runs (total runs = repeat+1)
cmd_pause  in  8  idle cycles between runs
packet_detect  in  1  sync packet-detect flag
rx_cmd_valid  out  1  command valid to RX core
rx_cmd_ready  in  1  RX core accepts command
rx_cmd_length  out  LEN_W  latched length
rx_cmd_mode  out  2  latched mode
rx_cmd_seed  out  7  latched seed
rx_start  out  1  one-cycle start pulse to RX core
rx_dout_valid  in  1  RX core output word strobe
dataq_full  in  1  data queue full
busy  out  1  state != IDLE
state  out  3  current state encoding
done  out  1  one-cycle completion pulse
done_status  out  2  0 ok, 1 timeout, 2 abort; held until next done
pkt_count  out  CNT_W  completed runs, saturating
timeout_count  out  CNT_W  timeouts, saturating
overflow_count  out  CNT_W  words strobed while dataq_full, saturating

Behaviour:
- Reset values: all outputs 0; state = IDLE; latched command fields 0.
- States: IDLE=0, LOAD=1, WAIT_DET=2, RUN=3, PAUSE=4, DONE=5.
- IDLE:
  - If enable && cmd_valid: assert cmd_ready combinationally for exactly one cycle and latch all cmd fields that cycle.
  - Set runs_left = cmd_repeat, then go to LOAD.
- LOAD:
  - rx_cmd_valid = 1, with fields driven from latches.
  - On rx_cmd_ready, go to WAIT_DET and clear the timeout counter.
- WAIT_DET:
  - On packet_detect: rx_start = 1 (registered, asserts the cycle after detect), clear the word counter, go to RUN.
  - Otherwise, if timeout_limit != 0, increment the timeout counter. When it equals timeout_limit: timeout_count++, done_status = 1, go to DONE. Remaining runs are discarded.
  - If packet_detect and the timeout hit occur in the same cycle, detect wins.
- RUN:
  - Each rx_dout_valid increments the word counter.
  - When the counter reaches length (0 is treated as 2**LEN_W), the last word is counted, pkt_count++ and the block goes to PAUSE.
  - rx_dout_valid && dataq_full increments overflow_count; the word is still counted.
- PAUSE:
  - Wait exactly cmd_pause cycles; 0 means leave on the next cycle.
  - Then, if runs_left != 0: decrement runs_left and go to LOAD. Otherwise done_status = 0 and go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE. The next command can be popped the cycle after that.
- Abort: enable low in any state other than IDLE or DONE:
  - Next state is DONE with done_status = 2.
  - rx_cmd_valid and rx_start drop immediately.
  - No pkt_count increment.
- Counters saturate at all-ones, and clear only on rst.
- rst mid-operation: return to IDLE next edge with all outputs at reset values; no done pulse.

Decomposition:
- Package ofdmbbp_rx_pkg holds:
  - state enum encodings;
  - done_status codes (ST_OK, ST_TIMEOUT, ST_ABORT);
  - default LEN_W and CNT_W.
- One sub-module, ofdmbbp_sat_cnt: a saturating counter with inc and width parameter. It is instanced three times, for pkt/timeout/overflow.

Test Plan:
- Single run: cmd length=4, repeat=0, pause=0; detect 10 cycles after LOAD; 4 dout strobes -> exactly one rx_start, done with status 0, pkt_count=1, cmd_ready pulsed once.
- Repeat: repeat=2, pause=3 -> three LOAD handshakes; PAUSE lasts 3 cycles each time; pkt_count=3; one done.
- Timeout: timeout_limit=20, no detect -> done_status=1 on the 20th WAIT_DET cycle; timeout_count=1; pkt_count unchanged.
- Overflow and length 0: length=0 with dataq_full high for 5 of the strobes -> RUN ends after 256 strobes; overflow_count=5.
- Abort and reset:
  - enable dropped mid-RUN -> done_status=2 with no pkt increment.
  - rst mid-WAIT_DET -> IDLE with no done pulse and all counters 0.
- Tie: packet_detect coincident with the timeout hit -> rx_start asserted; timeout_count unchanged.

Source files
------------

// File: rtl/ofdmbbp_rx_pkg.sv
// ofdmbbp_rx_pkg
// Shared constants for the OFDM baseband RX packet scheduler:
//   - state encodings exported on the scheduler's 'state' debug port
//   - done_status completion codes
//   - default widths for the status counters and the command length field
package ofdmbbp_rx_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int LEN_W_DEF = 8;

  // Scheduler FSM encodings (3-bit, visible on the 'state' port)
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_WAIT_DET = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_PAUSE    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  // Completion codes reported on done_status
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_ABORT   = 2'd2;

endpackage

// File: rtl/ofdmbbp_sat_cnt.sv
// ofdmbbp_sat_cnt
// Saturating up-counter used for the scheduler status counters.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset, clears the count
//   i_inc    increment request for this cycle
//   o_count  current count; sticks at all-ones once reached
module ofdmbbp_sat_cnt #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ofdmbbp_rx_sched.sv
// ofdmbbp_rx_sched
// Receive-packet sequencer between the software command queue and the RX
// demodulator core. Pops one command, loads it into the core, arms on the
// sync packet-detect flag, pulses rx_start, counts output words up to the
// commanded length, pauses, and repeats the command cmd_repeat extra times.
// Detect timeouts, data-queue overflow and software abort (enable low) are
// supervised and summarised in saturating status counters.
//
// Ports:
//   clk, rst                 sample clock, synchronous active-high reset
//   enable                   low aborts any operation in progress
//   timeout_limit            max WAIT_DET cycles, 0 disables the timeout
//   cmd_valid/cmd_ready      command queue; cmd_ready is a one-cycle pop strobe
//   cmd_length/mode/seed/repeat/pause   command fields (latched on pop)
//   packet_detect            sync packet-detect flag
//   rx_cmd_valid/rx_cmd_ready + rx_cmd_length/mode/seed   command to RX core
//   rx_start                 one-cycle start pulse to RX core
//   rx_dout_valid            RX core output word strobe
//   dataq_full               data queue full
//   busy, state              debug/status view of the FSM
//   done, done_status        completion pulse and held completion code
//   pkt_count, timeout_count, overflow_count   saturating status counters
//
// Handshakes: the RX command transfer occurs on a cycle where rx_cmd_valid
// and rx_cmd_ready are both high; rx_cmd_valid, once raised in LOAD, stays
// high with stable fields until that transfer or an abort. The command queue
// pop happens on any cycle where cmd_ready is high (cmd_ready implies
// cmd_valid).
module ofdmbbp_rx_sched
  import ofdmbbp_rx_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] timeout_limit,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_length,
  input  logic [1:0]       cmd_mode,
  input  logic [6:0]       cmd_seed,
  input  logic [6:0]       cmd_repeat,
  input  logic [7:0]       cmd_pause,
  input  logic             packet_detect,
  output logic             rx_cmd_valid,
  input  logic             rx_cmd_ready,
  output logic [LEN_W-1:0] rx_cmd_length,
  output logic [1:0]       rx_cmd_mode,
  output logic [6:0]       rx_cmd_seed,
  output logic             rx_start,
  input  logic             rx_dout_valid,
  input  logic             dataq_full,
  output logic             busy,
  output logic [2:0]       state,
  output logic             done,
  output logic [1:0]       done_status,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic [CNT_W-1:0] overflow_count
);

  logic [2:0]       r_state;
  logic [LEN_W-1:0] r_len;
  logic [1:0]       r_mode;
  logic [6:0]       r_seed;
  logic [7:0]       r_pause;
  logic [6:0]       r_runs_left;
  logic [CNT_W-1:0] r_tmo;
  logic [LEN_W:0]   r_words;
  logic [7:0]       r_pcnt;
  logic             r_rx_start;
  logic [1:0]       r_done_status;

  logic [2:0]       w_state_nxt;
  logic             w_active;
  logic             w_abort;
  logic             w_pop;
  logic [LEN_W:0]   w_word_target;
  logic [LEN_W:0]   w_words_nxt;
  logic             w_last_word;
  logic [CNT_W-1:0] w_tmo_nxt;
  logic             w_tmo_hit;
  logic             w_detect;
  logic             w_pause_end;
  logic             w_ovf_inc;

  // LOAD..PAUSE are the states an enable drop can abort
  assign w_active = (r_state == S_LOAD) || (r_state == S_WAIT_DET) ||
                    (r_state == S_RUN)  || (r_state == S_PAUSE);
  assign w_abort  = w_active && !enable;
  assign w_pop    = !rst && (r_state == S_IDLE) && enable && cmd_valid;

  // Length 0 stands for a full 2**LEN_W words, hence the extra counter bit
  assign w_word_target = (r_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, r_len};
  assign w_words_nxt   = r_words + {{LEN_W{1'b0}}, 1'b1};
  assign w_last_word   = (r_state == S_RUN) && enable && rx_dout_valid &&
                         (w_words_nxt == w_word_target);
  assign w_ovf_inc     = (r_state == S_RUN) && enable && rx_dout_valid && dataq_full;

  // A detect in the same cycle as the timeout hit wins
  assign w_detect  = (r_state == S_WAIT_DET) && enable && packet_detect;
  assign w_tmo_nxt = r_tmo + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_tmo_hit = (r_state == S_WAIT_DET) && enable && !packet_detect &&
                     (timeout_limit != '0) && (w_tmo_nxt == timeout_limit);

  // Pause of 0 still spends one cycle in PAUSE
  assign w_pause_end = ({1'b0, r_pcnt} + 9'd1) >= {1'b0, r_pause};

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_DONE;
    end else begin
      case (r_state)
        S_IDLE:     if (w_pop) w_state_nxt = S_LOAD;
        S_LOAD:     if (rx_cmd_ready) w_state_nxt = S_WAIT_DET;
        S_WAIT_DET: begin
          if (w_detect)       w_state_nxt = S_RUN;
          else if (w_tmo_hit) w_state_nxt = S_DONE;
        end
        S_RUN:      if (w_last_word) w_state_nxt = S_PAUSE;
        S_PAUSE: begin
          if (w_pause_end) w_state_nxt = (r_runs_left != 7'd0) ? S_LOAD : S_DONE;
        end
        S_DONE:     w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_mode        <= '0;
      r_seed        <= '0;
      r_pause       <= '0;
      r_runs_left   <= '0;
      r_tmo         <= '0;
      r_words       <= '0;
      r_pcnt        <= '0;
      r_rx_start    <= 1'b0;
      r_done_status <= ST_OK;
    end else begin
      r_state    <= w_state_nxt;
      r_rx_start <= w_detect && !w_abort;
      if (w_pop) begin
        r_len       <= cmd_length;
        r_mode      <= cmd_mode;
        r_seed      <= cmd_seed;
        r_pause     <= cmd_pause;
        r_runs_left <= cmd_repeat;
      end
      if ((r_state == S_LOAD) && rx_cmd_ready) r_tmo <= '0;
      else if (w_tmo_hit || ((r_state == S_WAIT_DET) && (timeout_limit != '0)))
        r_tmo <= w_tmo_nxt;
      if (w_detect) r_words <= '0;
      else if ((r_state == S_RUN) && enable && rx_dout_valid) r_words <= w_words_nxt;
      if (w_last_word) r_pcnt <= '0;
      else if (r_state == S_PAUSE) r_pcnt <= r_pcnt + 8'd1;
      if (!w_abort && (r_state == S_PAUSE) && w_pause_end && (r_runs_left != 7'd0))
        r_runs_left <= r_runs_left - 7'd1;
      if (w_abort) r_done_status <= ST_ABORT;
      else if (w_tmo_hit) r_done_status <= ST_TIMEOUT;
      else if ((r_state == S_PAUSE) && w_pause_end && (r_runs_left == 7'd0))
        r_done_status <= ST_OK;
    end
  end

  ofdmbbp_sat_cnt #(.W(CNT_W)) u_pkt_cnt (
    .i_clk(clk), .i_rst(rst), .i_inc(w_last_word), .o_count(pkt_count)
  );
  ofdmbbp_sat_cnt #(.W(CNT_W)) u_tmo_cnt (
    .i_clk(clk), .i_rst(rst), .i_inc(w_tmo_hit), .o_count(timeout_count)
  );
  ofdmbbp_sat_cnt #(.W(CNT_W)) u_ovf_cnt (
    .i_clk(clk), .i_rst(rst), .i_inc(w_ovf_inc), .o_count(overflow_count)
  );

  assign cmd_ready     = w_pop;
  assign rx_cmd_valid  = (r_state == S_LOAD) && enable;
  assign rx_cmd_length = r_len;
  assign rx_cmd_mode   = r_mode;
  assign rx_cmd_seed   = r_seed;
  assign rx_start      = r_rx_start && enable;
  assign busy          = (r_state != S_IDLE);
  assign state         = r_state;
  assign done          = (r_state == S_DONE);
  assign done_status   = r_done_status;

endmodule

// File: tb/tb_ofdmbbp_rx_sched.sv
// tb_ofdmbbp_rx_sched
// Directed bench for ofdmbbp_rx_sched. Inputs change on the falling edge,
// outputs are checked 1 time unit later; a monitor counts pulses per cycle.
module tb_ofdmbbp_rx_sched;
  localparam int CNT_W = 16;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] timeout_limit = '0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_length = '0;
  logic [1:0]       cmd_mode = '0;
  logic [6:0]       cmd_seed = '0;
  logic [6:0]       cmd_repeat = '0;
  logic [7:0]       cmd_pause = '0;
  logic             packet_detect = 1'b0;
  logic             rx_cmd_valid;
  logic             rx_cmd_ready = 1'b0;
  logic [LEN_W-1:0] rx_cmd_length;
  logic [1:0]       rx_cmd_mode;
  logic [6:0]       rx_cmd_seed;
  logic             rx_start;
  logic             rx_dout_valid = 1'b0;
  logic             dataq_full = 1'b0;
  logic             busy;
  logic [2:0]       state;
  logic             done;
  logic [1:0]       done_status;
  logic [CNT_W-1:0] pkt_count, timeout_count, overflow_count;

  int n_checks = 0;
  int n_fail = 0;
  int n_cmd_ready = 0, n_rx_start = 0, n_done = 0, n_hs = 0;

  ofdmbbp_rx_sched #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .timeout_limit(timeout_limit),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_length(cmd_length),
    .cmd_mode(cmd_mode), .cmd_seed(cmd_seed), .cmd_repeat(cmd_repeat),
    .cmd_pause(cmd_pause), .packet_detect(packet_detect),
    .rx_cmd_valid(rx_cmd_valid), .rx_cmd_ready(rx_cmd_ready),
    .rx_cmd_length(rx_cmd_length), .rx_cmd_mode(rx_cmd_mode),
    .rx_cmd_seed(rx_cmd_seed), .rx_start(rx_start),
    .rx_dout_valid(rx_dout_valid), .dataq_full(dataq_full), .busy(busy),
    .state(state), .done(done), .done_status(done_status),
    .pkt_count(pkt_count), .timeout_count(timeout_count),
    .overflow_count(overflow_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Pulse monitor: one sample per cycle, after inputs have settled
  always @(negedge clk) begin
    #2;
    if (cmd_ready) n_cmd_ready++;
    if (rx_start) n_rx_start++;
    if (done) n_done++;
    if (rx_cmd_valid && rx_cmd_ready) n_hs++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pop_cmd(input logic [7:0] len, input logic [6:0] rep, input logic [7:0] pause);
    cmd_valid = 1'b1; cmd_length = len; cmd_repeat = rep; cmd_pause = pause;
    cmd_mode = 2'd1; cmd_seed = 7'h2a;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic accept_load();
    rx_cmd_ready = 1'b1;
    tick();
    rx_cmd_ready = 1'b0;
  endtask

  task automatic detect_after(input int n);
    repeat (n - 1) tick();
    packet_detect = 1'b1;
    tick();
    packet_detect = 1'b0;
  endtask

  task automatic strobes(input int n, input int nfull);
    for (int i = 0; i < n; i++) begin
      rx_dout_valid = 1'b1;
      dataq_full = (i < nfull);
      tick();
    end
    rx_dout_valid = 1'b0;
    dataq_full = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; cmd_valid = 1'b1;
    repeat (3) tick();
    #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %0b want 0", cmd_ready); end
    n_checks++; if (state !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_state: got state=%0d busy=%0b want 0/0", state, busy); end
    n_checks++; if ({rx_cmd_valid, rx_start, done, done_status} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 00000", {rx_cmd_valid, rx_start, done, done_status}); end
    n_checks++; if ({pkt_count, timeout_count, overflow_count} !== 48'h0) begin n_fail++; $display("FAIL reset_counts: got %0h/%0h/%0h want 0/0/0", pkt_count, timeout_count, overflow_count); end
    n_checks++; if ({rx_cmd_length, rx_cmd_mode, rx_cmd_seed} !== 17'h0) begin n_fail++; $display("FAIL reset_fields: got %0h want 0", {rx_cmd_length, rx_cmd_mode, rx_cmd_seed}); end
    cmd_valid = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int b_cr, b_st, b_dn;
    b_cr = n_cmd_ready; b_st = n_rx_start; b_dn = n_done;
    timeout_limit = '0;
    cmd_valid = 1'b1; cmd_length = 8'd4; cmd_mode = 2'd2; cmd_seed = 7'h55;
    cmd_repeat = 7'd0; cmd_pause = 8'd0;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL single_cmd_ready: got %0b want 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0; cmd_length = '0; cmd_mode = '0; cmd_seed = '0;
    #1;
    n_checks++; if (state !== 3'd1 || rx_cmd_valid !== 1'b1) begin n_fail++; $display("FAIL single_load: got state=%0d valid=%0b want 1/1", state, rx_cmd_valid); end
    n_checks++; if (rx_cmd_length !== 8'd4 || rx_cmd_mode !== 2'd2 || rx_cmd_seed !== 7'h55) begin n_fail++; $display("FAIL single_fields: got %0h/%0h/%0h want 4/2/55", rx_cmd_length, rx_cmd_mode, rx_cmd_seed); end
    accept_load();
    detect_after(10);
    #1;
    n_checks++; if (state !== 3'd3 || rx_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got state=%0d start=%0b want 3/1", state, rx_start); end
    strobes(4, 0);
    #1;
    n_checks++; if (state !== 3'd4 || pkt_count !== 16'd1) begin n_fail++; $display("FAIL single_pause: got state=%0d pkt=%0d want 4/1", state, pkt_count); end
    tick(); #1;
    n_checks++; if (done !== 1'b1 || done_status !== 2'd0) begin n_fail++; $display("FAIL single_done: got done=%0b status=%0d want 1/0", done, done_status); end
    tick(); #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%0b done=%0b want 0/0", busy, done); end
    n_checks++; if ((n_cmd_ready - b_cr) != 1 || (n_rx_start - b_st) != 1 || (n_done - b_dn) != 1) begin n_fail++; $display("FAIL single_pulses: got pop=%0d start=%0d done=%0d want 1/1/1", n_cmd_ready - b_cr, n_rx_start - b_st, n_done - b_dn); end
  endtask

  task automatic test_repeat();
    int b_hs, b_dn, bad_pause;
    b_hs = n_hs; b_dn = n_done; bad_pause = 0;
    pop_cmd(8'd2, 7'd2, 8'd3);
    for (int r = 0; r < 3; r++) begin
      #1;
      n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL repeat_load%0d: got state=%0d want 1", r, state); end
      accept_load();
      detect_after(2);
      strobes(2, 0);
      for (int p = 0; p < 3; p++) begin
        #1; if (state !== 3'd4) bad_pause++;
        tick();
      end
    end
    #1;
    n_checks++; if (bad_pause != 0) begin n_fail++; $display("FAIL repeat_pause_len: got %0d non-PAUSE cycles want 0", bad_pause); end
    n_checks++; if (done !== 1'b1 || done_status !== 2'd0) begin n_fail++; $display("FAIL repeat_done: got done=%0b status=%0d want 1/0", done, done_status); end
    tick(); #1;
    n_checks++; if (pkt_count !== 16'd4) begin n_fail++; $display("FAIL repeat_pkt: got %0d want 4", pkt_count); end
    n_checks++; if ((n_hs - b_hs) != 3 || (n_done - b_dn) != 1) begin n_fail++; $display("FAIL repeat_pulses: got hs=%0d done=%0d want 3/1", n_hs - b_hs, n_done - b_dn); end
  endtask

  task automatic test_timeout();
    int b_st;
    b_st = n_rx_start;
    timeout_limit = 16'd20;
    pop_cmd(8'd4, 7'd5, 8'd0);
    accept_load();
    repeat (19) tick();
    #1;
    n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL timeout_wait20: got state=%0d want 2", state); end
    tick(); #1;
    n_checks++; if (done !== 1'b1 || done_status !== 2'd1) begin n_fail++; $display("FAIL timeout_done: got done=%0b status=%0d want 1/1", done, done_status); end
    n_checks++; if (timeout_count !== 16'd1 || pkt_count !== 16'd4) begin n_fail++; $display("FAIL timeout_counts: got tmo=%0d pkt=%0d want 1/4", timeout_count, pkt_count); end
    tick(); #1;
    n_checks++; if (state !== 3'd0 || (n_rx_start - b_st) != 0) begin n_fail++; $display("FAIL timeout_idle: got state=%0d starts=%0d want 0/0", state, n_rx_start - b_st); end
  endtask

  task automatic test_overflow_len0();
    timeout_limit = '0;
    pop_cmd(8'd0, 7'd0, 8'd0);
    accept_load();
    detect_after(1);
    dataq_full = 1'b1;
    tick();
    dataq_full = 1'b0;
    strobes(255, 5);
    #1;
    n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL len0_255: got state=%0d want 3", state); end
    strobes(1, 0);
    #1;
    n_checks++; if (state !== 3'd4 || pkt_count !== 16'd5) begin n_fail++; $display("FAIL len0_256: got state=%0d pkt=%0d want 4/5", state, pkt_count); end
    n_checks++; if (overflow_count !== 16'd5) begin n_fail++; $display("FAIL overflow_count: got %0d want 5", overflow_count); end
    repeat (2) tick();
  endtask

  task automatic test_abort();
    pop_cmd(8'd1, 7'd0, 8'd0);
    enable = 1'b0; rx_cmd_ready = 1'b1;
    #1;
    n_checks++; if (rx_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL abort_load_valid: got %0b want 0", rx_cmd_valid); end
    tick(); rx_cmd_ready = 1'b0; #1;
    n_checks++; if (state !== 3'd5 || done_status !== 2'd2) begin n_fail++; $display("FAIL abort_load: got state=%0d status=%0d want 5/2", state, done_status); end
    tick(); enable = 1'b1;
    pop_cmd(8'd1, 7'd0, 8'd0);
    accept_load();
    detect_after(1);
    enable = 1'b0; rx_dout_valid = 1'b1;
    #1;
    n_checks++; if (rx_start !== 1'b0) begin n_fail++; $display("FAIL abort_run_start: got %0b want 0", rx_start); end
    tick(); rx_dout_valid = 1'b0; #1;
    n_checks++; if (done !== 1'b1 || done_status !== 2'd2 || pkt_count !== 16'd5) begin n_fail++; $display("FAIL abort_run: got done=%0b status=%0d pkt=%0d want 1/2/5", done, done_status, pkt_count); end
    tick(); enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int b_dn;
    b_dn = n_done;
    pop_cmd(8'd4, 7'd3, 8'd0);
    accept_load();
    repeat (2) tick();
    #1;
    n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL rstmid_pre: got state=%0d want 2", state); end
    rst = 1'b1;
    tick(); #1;
    n_checks++; if (state !== 3'd0 || done !== 1'b0 || done_status !== 2'd0 || rx_cmd_length !== 8'd0) begin n_fail++; $display("FAIL rstmid_state: got state=%0d done=%0b status=%0d len=%0d want 0/0/0/0", state, done, done_status, rx_cmd_length); end
    n_checks++; if ({pkt_count, timeout_count, overflow_count} !== 48'h0) begin n_fail++; $display("FAIL rstmid_counts: got %0h/%0h/%0h want 0/0/0", pkt_count, timeout_count, overflow_count); end
    rst = 1'b0;
    tick(); #1;
    n_checks++; if ((n_done - b_dn) != 0 || state !== 3'd0) begin n_fail++; $display("FAIL rstmid_nodone: got dones=%0d state=%0d want 0/0", n_done - b_dn, state); end
  endtask

  task automatic test_tie();
    timeout_limit = 16'd5;
    pop_cmd(8'd2, 7'd0, 8'd0);
    accept_load();
    detect_after(5);
    #1;
    n_checks++; if (state !== 3'd3 || rx_start !== 1'b1 || timeout_count !== 16'd0) begin n_fail++; $display("FAIL tie: got state=%0d start=%0b tmo=%0d want 3/1/0", state, rx_start, timeout_count); end
    strobes(2, 0);
    tick(); #1;
    n_checks++; if (done !== 1'b1 || done_status !== 2'd0 || pkt_count !== 16'd1) begin n_fail++; $display("FAIL tie_done: got done=%0b status=%0d pkt=%0d want 1/0/1", done, done_status, pkt_count); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_timeout();
    test_overflow_len0();
    test_abort();
    test_reset_mid();
    test_tie();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
